// File: rtl/q_8_41_unpacker_if.sv
// Handshake bundle for the 16-to-8 unpacker: upstream word channel plus
// downstream byte channel. The unpacker uses the slave view; its source/sink uses master.
interface q_8_41_unpacker_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/q_8_41_unpacker.sv
// Splits each packed 16-bit word {P1,P0} into two 8-bit samples, P0 first,
// sustaining one sample per cycle and counting samples taken downstream.
module q_8_41_unpacker (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    q_8_41_unpacker_if.slave        bus,
    output logic [15:0]             byte_count,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_word;
    logic [15:0] r_byteCount;
    logic        w_loadWord;
    logic        w_inAccept;
    logic        w_outAccept;
    logic        w_inReady;
    logic        w_outValid;

    // out_ready -> in_ready is the only combinational path, so a word can be
    // taken in the same cycle the high byte leaves.
    assign w_inReady   = ~clr & ((r_state == IDLE) | ((r_state == HI) & bus.out_ready));
    assign w_outValid  = (r_state == LO) | (r_state == HI);
    assign w_inAccept  = bus.in_valid & w_inReady;
    assign w_outAccept = w_outValid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_loadWord  = 1'b0;
        if (clr) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_inAccept) begin
                        w_nextState = LO;
                        w_loadWord  = 1'b1;
                    end
                end
                LO: begin
                    if (w_outAccept) begin
                        w_nextState = HI;
                    end
                end
                HI: begin
                    if (w_outAccept) begin
                        if (w_inAccept) begin
                            w_nextState = LO;
                            w_loadWord  = 1'b1;
                        end else begin
                            w_nextState = IDLE;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // The word only loads when the previous one has fully left, so it is
    // never disturbed while a byte is stalled downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= 16'h0000;
        end else if (clr) begin
            r_word <= 16'h0000;
        end else if (w_loadWord) begin
            r_word <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byteCount <= 16'h0000;
        end else if (clr) begin
            r_byteCount <= 16'h0000;
        end else if (w_outAccept) begin
            r_byteCount <= r_byteCount + 16'h0001;
        end
    end

    always_comb begin
        bus.out_data = 8'h00;
        case (r_state)
            LO:      bus.out_data = r_word[7:0];
            HI:      bus.out_data = r_word[15:8];
            default: bus.out_data = 8'h00;
        endcase
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.out_last  = (r_state == HI);
    assign byte_count    = r_byteCount;
    assign busy          = (r_state != IDLE);

endmodule

// File: doc/q_8_41_unpacker.md
Q_8_41_UNPACKER -- requirements
Module: q_8_41_unpacker

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port clr  input  1  synchronous clear; drops the held word and zeroes byte_count.
REQ-004 SHALL have port in_valid  input  1  upstream word valid.
REQ-005 SHALL have port in_data  input  16  packed word, {P1,P0}; P0 = older sample in [7:0], P1 = newer sample in [15:8].
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-009 SHALL have port out_data  output  8  unpacked 8-bit sample.
REQ-010 SHALL have port out_last  output  1  high while the second (high) byte of a word is presented.
REQ-011 SHALL have port byte_count  output  16  count of samples accepted downstream, wraps 0xFFFF->0x0000.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, LO, HI; word register W[15:0] holds the accepted word.
REQ-014 SHALL define in_accept = in_valid & in_ready and out_accept = out_valid & out_ready.
REQ-015 SHALL drive in_ready = ~clr & ((state==IDLE) | (state==HI & out_ready)); the only combinational input-to-output path is out_ready->in_ready.
REQ-016 SHALL drive out_valid = (state==LO | state==HI); out_data = W[7:0] in LO, W[15:8] in HI; out_last = (state==HI); all are decoded from registers only.
REQ-017 SHALL handle IDLE as: in_accept -> W<=in_data, go LO; otherwise stay IDLE.
REQ-018 SHALL handle LO as: out_accept -> go HI; otherwise hold state, W, and out_data stable.
REQ-019 SHALL handle HI as: out_accept & in_accept -> W<=in_data, go LO (back-to-back, no bubble); out_accept & ~in_valid -> go IDLE; ~out_accept -> hold.
REQ-020 SHALL, on a word accepted at edge N, present the low byte with out_valid=1 in cycle N+1 (latency 1 cycle).
REQ-021 SHALL sustain 1 sample per cycle, i.e. one word per 2 cycles, under continuous in_valid and out_ready.
REQ-022 SHALL emit P0 (W[7:0]) before P1 (W[15:8]), so two words fed to the matching decimator reproduce the original sample order.
REQ-023 SHALL increment byte_count by 1 on every out_accept, modulo 2^16.
REQ-024 SHALL never change W while out_valid=1 and out_ready=0.
REQ-025 SHALL give clr priority over all other events: next state IDLE, byte_count<=0, W<=0, and no word is accepted in a cycle with clr=1.
REQ-026 SHALL ignore in_data when in_valid=0, and ignore out_ready when out_valid=0.

Reset
REQ-027 SHALL, while rst_n=0, force state=IDLE, W=0, and byte_count=0, giving out_valid=0, out_last=0, out_data=0x00, busy=0, and in_ready=1.
REQ-028 SHALL, when rst_n is asserted mid-word (LO or HI), abandon the word immediately without completing it.
REQ-029 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL pass the single-word test: in_data=0xA55A accepted, out_ready=1 -> out_data 0x5A (out_last=0), then 0xA5 (out_last=1), then out_valid=0; byte_count=2.
REQ-031 SHALL pass the streaming test: words 0x1122, 0x3344, 0x5566 offered back-to-back with out_ready=1 -> bytes 22,11,44,33,66,55 on consecutive cycles with no bubble; in_ready pulses in IDLE/HI only.
REQ-032 SHALL pass the backpressure test: word 0xBEEF accepted, out_ready=0 for 5 cycles -> out_data holds 0xEF, in_ready=0; on release, 0xEF then 0xBE.
REQ-033 SHALL pass the mid-word clear test: clr=1 while 0x00FF is presented -> next cycle out_valid=0, byte_count=0, and the pending 0x00 byte is never emitted.
REQ-034 SHALL pass the async reset test: rst_n=0 between clock edges while in HI -> outputs take their reset values immediately, without waiting for clk.
REQ-035 SHALL pass the wrap test: byte_count preloaded to 0xFFFE via traffic, 2 accepts -> byte_count = 0x0000.
